// File: rtl/mack_bus_if.sv
// 68000-style bus signals between CPU/decoder/peripherals and the DTACK/BERR controller.
interface mack_bus_if;
  logic AS;
  logic IACK;
  logic ROMEN;
  logic RAMEN;
  logic MFPEN;
  logic DUARTEN;
  logic DTACK_IN;
  logic DTACK;
  logic BERR;

  modport master (
    output AS, IACK, ROMEN, RAMEN, MFPEN, DUARTEN, DTACK_IN,
    input  DTACK, BERR
  );

  modport slave (
    input  AS, IACK, ROMEN, RAMEN, MFPEN, DUARTEN, DTACK_IN,
    output DTACK, BERR
  );
endinterface

// File: rtl/mack_bus_ctrl.sv
// DTACK/BERR generator for a 68000 bus: wait-stated ROM/RAM, peripheral DTACK pass-through.
// Optional bus-error timeout is enabled by defining MACK_BERR_TIMEOUT_EN.
module mack_bus_ctrl #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic       CLK,
  input logic       RST,
  mack_bus_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StFault} state_e;
  typedef enum logic [1:0] {ClsNone, ClsRom, ClsRam, ClsPeriph} class_e;

  localparam logic [7:0] RomWaitL = 8'(ROM_WAIT);
  localparam logic [7:0] RamWaitL = 8'(RAM_WAIT);

  state_e     r_state, w_state_nxt;
  class_e     r_class, w_class_nxt;
  logic [7:0] r_wcnt, w_wcnt_nxt;
  logic       w_ack;
  logic       r_as, r_iack, r_romen, r_ramen, r_mfpen, r_duarten, r_dtack_in;
  logic       r_dtack;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_as       <= 1'b1;
      r_iack     <= 1'b1;
      r_romen    <= 1'b1;
      r_ramen    <= 1'b1;
      r_mfpen    <= 1'b1;
      r_duarten  <= 1'b1;
      r_dtack_in <= 1'b1;
      r_state    <= StIdle;
      r_class    <= ClsNone;
      r_wcnt     <= 8'd0;
      r_dtack    <= 1'b1;
    end else begin
      r_as       <= bus.AS;
      r_iack     <= bus.IACK;
      r_romen    <= bus.ROMEN;
      r_ramen    <= bus.RAMEN;
      r_mfpen    <= bus.MFPEN;
      r_duarten  <= bus.DUARTEN;
      r_dtack_in <= bus.DTACK_IN;
      r_state    <= w_state_nxt;
      r_class    <= w_class_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_dtack    <= (w_state_nxt != StAck);
    end
  end

`ifdef MACK_BERR_TIMEOUT_EN
  localparam logic [7:0] TimeoutL = 8'(TIMEOUT);
  logic [7:0] r_tcnt, w_tcnt_nxt;
  logic       r_berr;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_tcnt <= 8'd0;
      r_berr <= 1'b1;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_berr <= (w_state_nxt != StFault);
    end
  end

  assign bus.BERR = r_berr;
`else
  assign bus.BERR = 1'b1;
`endif

  assign bus.DTACK = r_dtack;

  always_comb begin
    w_state_nxt = r_state;
    w_class_nxt = r_class;
    w_wcnt_nxt  = r_wcnt;
    w_ack       = 1'b0;
`ifdef MACK_BERR_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (!r_as) begin
          // RAMEN overlaps the other selects, so it is checked last
          if (!r_iack || !r_mfpen || !r_duarten) w_class_nxt = ClsPeriph;
          else if (!r_romen)                     w_class_nxt = ClsRom;
          else if (!r_ramen)                     w_class_nxt = ClsRam;
          else                                   w_class_nxt = ClsNone;
          w_wcnt_nxt  = !r_romen ? RomWaitL : RamWaitL;
`ifdef MACK_BERR_TIMEOUT_EN
          w_tcnt_nxt  = 8'd0;
`endif
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        unique case (r_class)
          ClsRom, ClsRam: begin
            if (r_wcnt == 8'd0) w_ack = 1'b1;
            else                w_wcnt_nxt = r_wcnt - 8'd1;
          end
          ClsPeriph: w_ack = !r_dtack_in;
          ClsNone:   w_ack = 1'b0;
        endcase
`ifdef MACK_BERR_TIMEOUT_EN
        if (r_tcnt != 8'hFF) w_tcnt_nxt = r_tcnt + 8'd1;
`endif
        // Abort beats acknowledge, acknowledge beats timeout
        if (r_as)       w_state_nxt = StIdle;
        else if (w_ack) w_state_nxt = StAck;
`ifdef MACK_BERR_TIMEOUT_EN
        else if (r_tcnt == TimeoutL) w_state_nxt = StFault;
`endif
      end
      StAck: begin
        if (r_as) w_state_nxt = StIdle;
      end
      StFault: begin
        if (r_as) w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mack_bus_ctrl.sv
// Scoreboard bench for mack_bus_ctrl: expected DTACK/BERR edges are queued with their cycle
// when stimulus is driven, and matched against edges seen on the bus.
module tb_mack_bus_ctrl;
  localparam int unsigned RomW = 2;
  localparam int unsigned RamW = 0;
  localparam int unsigned Tmo  = 64;

  localparam int EvDtFall = 0;
  localparam int EvDtRise = 1;
  localparam int EvBeFall = 2;
  localparam int EvBeRise = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mack_bus_if bus();

  mack_bus_ctrl #(
    .ROM_WAIT (RomW),
    .RAM_WAIT (RamW),
    .TIMEOUT  (Tmo)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int    kind;
    int    at;
    string tag;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input string tag);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      check($sformatf("spurious_ev%0d_cyc", kind), cyc, -1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_kind"}, kind, e.kind);
      check({e.tag, "_cyc"}, cyc, e.at);
    end
  endtask

  logic prev_dt = 1'b1;
  logic prev_be = 1'b1;
  bit   mon_en  = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (prev_dt && !bus.DTACK) observe(EvDtFall);
      if (!prev_dt && bus.DTACK) observe(EvDtRise);
      if (prev_be && !bus.BERR)  observe(EvBeFall);
      if (!prev_be && bus.BERR)  observe(EvBeRise);
      if (!bus.DTACK || !bus.BERR) check("dtack_berr_excl", int'(bus.DTACK | bus.BERR), 1);
    end
    prev_dt <= bus.DTACK;
    prev_be <= bus.BERR;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle_bus();
    bus.AS       = 1'b1;
    bus.IACK     = 1'b1;
    bus.ROMEN    = 1'b1;
    bus.RAMEN    = 1'b1;
    bus.MFPEN    = 1'b1;
    bus.DUARTEN  = 1'b1;
    bus.DTACK_IN = 1'b1;
  endtask

  // Called at a negedge; AS is first sampled on the following posedge (number c+1).
  task automatic start_cycle(input logic rom, input logic ram, input logic mfp,
                             input logic duart, input logic iack, output int c);
    bus.ROMEN   = rom;
    bus.RAMEN   = ram;
    bus.MFPEN   = mfp;
    bus.DUARTEN = duart;
    bus.IACK    = iack;
    bus.AS      = 1'b0;
    c = cyc;
  endtask

  task automatic end_cycle(output int r);
    idle_bus();
    r = cyc;
  endtask

  // Peripheral cycle: DTACK_IN asserted after dly clocks of WAIT.
  task automatic periph_cycle(input logic rom, input logic ram, input logic mfp,
                              input logic duart, input logic iack, input int dly,
                              input string tag);
    int c, d, r;
    start_cycle(rom, ram, mfp, duart, iack, c);
    tick(dly);
    bus.DTACK_IN = 1'b0;
    d = cyc;
    expect_ev(EvDtFall, d + 2, {tag, "_fall"});
    tick(4);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, {tag, "_rise"});
    tick(3);
  endtask

  initial begin
    int c, r, q;
    idle_bus();
    RST = 1'b0;
    tick(3);
    check("rst_dtack", int'(bus.DTACK), 1);
    check("rst_berr", int'(bus.BERR), 1);
    RST = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // ROM (RAMEN overlapping)
    start_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, c);
    expect_ev(EvDtFall, c + RomW + 3, "rom_fall");
    tick(RomW + 6);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, "rom_rise");
    tick(3);

    // RAM only
    start_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, c);
    expect_ev(EvDtFall, c + RamW + 3, "ram_fall");
    tick(RamW + 6);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, "ram_rise");
    tick(3);

    periph_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5, "duart");
    periph_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, "mfp_over_rom");
    periph_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6, "iack_over_rom");

    // Back-to-back ROM cycles, AS high for a single clock
    start_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c);
    expect_ev(EvDtFall, c + RomW + 3, "b2b1_fall");
    tick(RomW + 6);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, "b2b1_rise");
    tick(1);
    start_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c);
    expect_ev(EvDtFall, c + RomW + 3, "b2b2_fall");
    tick(RomW + 6);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, "b2b2_rise");
    tick(3);

    // Aborted ROM cycle: no edges expected
    start_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c);
    tick(1);
    idle_bus();
    tick(RomW + 6);

    // Reset while DTACK low, then the still-asserted AS restarts a cycle
    start_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c);
    expect_ev(EvDtFall, c + RomW + 3, "prerst_fall");
    tick(RomW + 5);
    RST = 1'b0;
    r = cyc;
    expect_ev(EvDtRise, r + 1, "rst_rise");
    tick(2);
    RST = 1'b1;
    q = cyc;
    expect_ev(EvDtFall, q + RomW + 3, "postrst_fall");
    tick(RomW + 6);
    end_cycle(r);
    expect_ev(EvDtRise, r + 2, "postrst_rise");
    tick(3);

    // Unmapped access
    start_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, c);
`ifdef MACK_BERR_TIMEOUT_EN
    expect_ev(EvBeFall, c + Tmo + 3, "tmo_berr_fall");
`endif
    tick(Tmo + 6);
    end_cycle(r);
`ifdef MACK_BERR_TIMEOUT_EN
    expect_ev(EvBeRise, r + 2, "tmo_berr_rise");
`endif
    tick(3);

    // DTACK_IN lands on the same edge the timeout would fire
    periph_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, Tmo + 1, "race");

    check("final_dtack", int'(bus.DTACK), 1);
    check("final_berr", int'(bus.BERR), 1);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t expected finish before it", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mack_bus_ctrl.md
MACK_BUS_CTRL -- requirements
Module: mack_bus_ctrl

Interface
REQ-001 The block SHALL have parameter ROM_WAIT, default 2, meaning clocks of delay before DTACK on ROM cycles.
REQ-002 The block SHALL have parameter RAM_WAIT, default 0, meaning clocks of delay before DTACK on RAM cycles.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning clocks of AS low without acknowledge before bus error (range 8..255).
REQ-004 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-005 Port: RST  input  1  synchronous reset, active-low.
REQ-006 Port: AS  input  1  68000 address strobe, active-low.
REQ-007 Port: IACK  input  1  interrupt-acknowledge qualifier, active-low (high = normal cycle).
REQ-008 Port: ROMEN, RAMEN, MFPEN, DUARTEN  input  1 each  chip selects from the address decoder, active-low.
REQ-009 Port: DTACK_IN  input  1  peripheral (MFP/DUART) DTACK, active-low.
REQ-010 Port: DTACK  output  1  acknowledge to CPU, active-low, registered.
REQ-011 Port: BERR  output  1  bus error to CPU, active-low, registered.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, ACK, FAULT; each cycle the FSM samples AS and the selects registered one clock.
REQ-013 IDLE: on registered AS low, FSM SHALL latch a cycle class by priority MFP > DUART > ROM > RAM (RAMEN overlaps others and is lowest), load wait counter, clear timeout counter, go to WAIT.
REQ-014 IACK cycle (IACK low with AS low) SHALL be classed PERIPH regardless of selects.
REQ-015 No select asserted and not IACK SHALL be classed NONE; only timeout can end it.
REQ-016 WAIT, class ROM/RAM: counter SHALL decrement each clock; at zero FSM goes to ACK, so DTACK falls exactly ROM_WAIT+2 / RAM_WAIT+2 clocks after AS first sampled low.
REQ-017 WAIT, class PERIPH: FSM SHALL go to ACK on the clock after registered DTACK_IN low.
REQ-018 ACK: DTACK SHALL be held low until registered AS high, then DTACK high and FSM to IDLE on that same edge.
REQ-019 Timeout counter SHALL increment each clock in WAIT, saturating at 8 bits; on reaching TIMEOUT FSM SHALL go to FAULT.
REQ-020 FAULT: BERR SHALL be held low, DTACK high, until registered AS high, then BERR high, IDLE.
REQ-021 Simultaneous acknowledge and timeout on the same edge: acknowledge SHALL win (ACK, no BERR).
REQ-022 AS negated during WAIT (aborted cycle) SHALL return FSM to IDLE with no DTACK/BERR pulse.
REQ-023 DTACK and BERR SHALL never be low in the same clock.
REQ-024 AS back-to-back (high for one registered clock) SHALL start a fresh cycle with counters reloaded.

Reset
REQ-025 While RST low at a clock edge: state IDLE, DTACK=1, BERR=1, counters 0, input registers set to 1 (negated).
REQ-026 Reset asserted mid-cycle SHALL negate DTACK/BERR on the next edge; after release a cycle already in progress SHALL be treated as new once AS is sampled low.

Configuration
REQ-027 Macro MACK_BERR_TIMEOUT_EN defined: timeout counter and FAULT state SHALL be present per REQ-019..REQ-021.
REQ-028 Macro MACK_BERR_TIMEOUT_EN undefined: no timeout logic, BERR SHALL be tied high, class NONE SHALL wait in WAIT indefinitely until AS high.

Verification
REQ-029 ROM read: AS low with ROMEN and RAMEN low, defaults -> DTACK low 4 clocks after AS low, high 1 clock after AS high.
REQ-030 RAM read, RAM_WAIT=0: AS low, RAMEN only -> DTACK low 2 clocks after AS low.
REQ-031 DUART access: DUARTEN+RAMEN low, DTACK_IN low 5 clocks later -> DTACK low 2 clocks after DTACK_IN; no ROM/RAM-timed DTACK.
REQ-032 Unmapped with macro defined, TIMEOUT=64: AS low, no selects, no DTACK_IN -> BERR low at clock 66, released after AS high; DTACK stays high.
REQ-033 Abort and reset: AS high at clock 2 of a ROM_WAIT=2 cycle -> no DTACK; RST low while DTACK low -> DTACK high next edge.
REQ-034 Race: PERIPH cycle with DTACK_IN arriving on the timeout edge -> DTACK low, BERR stays high.
